// File: rtl/mandelbrot_engine.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_engine
// Purpose  : Escape-time iterator for one pixel, in Mandelbrot or Julia mode.
//            It performs one z <- z^2 + c update per cycle on signed
//            fixed-point values (WIDTH bits, FRAC fractional bits). It stops
//            when |z|^2 >= 4 or when the iteration count reaches max_iter.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready  : request handshake (in_re, in_im, mode,
//                                 julia_re, julia_im, max_iter, in_tag)
//            abort              : synchronous cancel of the job in flight
//            out_valid/out_ready: result handshake (out_iter, out_escaped,
//                                 out_tag)
// Revision : 1.0  initial release
// ============================================================================
module mandelbrot_engine #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int ITER_W = 16,
    parameter int TAG_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] julia_re,
    input  logic signed [WIDTH-1:0] julia_im,
    input  logic [ITER_W-1:0]       max_iter,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ITER_W-1:0]       out_iter,
    output logic                    out_escaped,
    output logic [TAG_W-1:0]        out_tag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 4.0 expressed in the 2*FRAC fractional bits of a squared magnitude.
    localparam logic [2*WIDTH:0] C_ESC_THRESH =
        {{(2*WIDTH-2){1'b0}}, 3'b100} << (2*FRAC);
    localparam logic [ITER_W-1:0] C_ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   z_re_q, z_re_d, z_im_q, z_im_d;
    logic signed [WIDTH-1:0]   c_re_q, c_re_d, c_im_q, c_im_d;
    logic [ITER_W-1:0]         iter_q, iter_d, limit_q, limit_d;
    logic [ITER_W-1:0]         out_iter_q, out_iter_d;
    logic                      out_escaped_q, out_escaped_d;
    logic [TAG_W-1:0]          tag_q, tag_d;

    // Full-precision products: operands are sign-extended to 2*WIDTH first,
    // so the low 2*WIDTH bits of each product are exact.
    logic signed [2*WIDTH-1:0] w_re_ext, w_im_ext;
    logic signed [2*WIDTH-1:0] w_sq_re, w_sq_im, w_cross, w_cross2, w_diff;
    logic [2*WIDTH:0]          w_mag;
    logic                      w_esc;
    logic signed [WIDTH-1:0]   w_re_next, w_im_next;
    logic                      w_unused;

    assign w_re_ext = {{WIDTH{z_re_q[WIDTH-1]}}, z_re_q};
    assign w_im_ext = {{WIDTH{z_im_q[WIDTH-1]}}, z_im_q};
    assign w_sq_re  = w_re_ext * w_re_ext;
    assign w_sq_im  = w_im_ext * w_im_ext;
    assign w_cross  = w_re_ext * w_im_ext;
    assign w_cross2 = w_cross <<< 1;
    assign w_diff   = w_sq_re - w_sq_im;

    // Both squares are non-negative; one extra bit keeps the sum exact.
    assign w_mag = {1'b0, w_sq_re} + {1'b0, w_sq_im};
    assign w_esc = (w_mag >= C_ESC_THRESH);

    // Taking bits [FRAC +: WIDTH] is an arithmetic shift by FRAC followed by
    // truncation to WIDTH bits.
    assign w_re_next = w_diff[FRAC +: WIDTH] + c_re_q;
    assign w_im_next = w_cross2[FRAC +: WIDTH] + c_im_q;

    // Bits outside the retained window are intentionally dropped.
    assign w_unused = ^{w_diff, w_cross2};

    always_comb begin
        state_d       = state_q;
        z_re_d        = z_re_q;
        z_im_d        = z_im_q;
        c_re_d        = c_re_q;
        c_im_d        = c_im_q;
        iter_d        = iter_q;
        limit_d       = limit_q;
        out_iter_d    = out_iter_q;
        out_escaped_d = out_escaped_q;
        tag_d         = tag_q;

        case (state_q)
            S_IDLE: begin
                // abort has no meaning here; a request is always taken.
                if (in_valid) begin
                    z_re_d  = in_re;
                    z_im_d  = in_im;
                    c_re_d  = mode ? julia_re : in_re;
                    c_im_d  = mode ? julia_im : in_im;
                    limit_d = max_iter;
                    tag_d   = in_tag;
                    iter_d  = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_esc || (iter_q == limit_q)) begin
                    out_iter_d    = iter_q;
                    out_escaped_d = w_esc;
                    state_d       = S_DONE;
                end else begin
                    z_re_d = w_re_next;
                    z_im_d = w_im_next;
                    iter_d = iter_q + C_ITER_ONE;
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            z_re_q        <= '0;
            z_im_q        <= '0;
            c_re_q        <= '0;
            c_im_q        <= '0;
            iter_q        <= '0;
            limit_q       <= '0;
            out_iter_q    <= '0;
            out_escaped_q <= 1'b0;
            tag_q         <= '0;
        end else begin
            state_q       <= state_d;
            z_re_q        <= z_re_d;
            z_im_q        <= z_im_d;
            c_re_q        <= c_re_d;
            c_im_q        <= c_im_d;
            iter_q        <= iter_d;
            limit_q       <= limit_d;
            out_iter_q    <= out_iter_d;
            out_escaped_q <= out_escaped_d;
            tag_q         <= tag_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_iter    = out_iter_q;
    assign out_escaped = out_escaped_q;
    assign out_tag     = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandelbrot_engine
// Purpose  : Self-checking bench for mandelbrot_engine. A fixed-point
//            escape-time model predicts each accepted job's count, escape
//            flag, tag and output cycle. A negedge monitor compares every
//            cycle against that prediction. Directed jobs pin known orbits.
// Revision : 1.0  initial release
// ============================================================================
module tb_mandelbrot_engine;

    localparam int WIDTH  = 32;
    localparam int FRAC   = 16;
    localparam int ITER_W = 16;
    localparam int TAG_W  = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              mode = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  in_re = '0, in_im = '0, julia_re = '0, julia_im = '0;
    logic [ITER_W-1:0] max_iter = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              in_ready, out_valid, out_escaped;
    logic [ITER_W-1:0] out_iter;
    logic [TAG_W-1:0]  out_tag;

    mandelbrot_engine #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ITER_W(ITER_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .mode       (mode),
        .julia_re   (julia_re),
        .julia_im   (julia_im),
        .max_iter   (max_iter),
        .in_tag     (in_tag),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_iter   (out_iter),
        .out_escaped(out_escaped),
        .out_tag    (out_tag)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Escape-time reference: plain 64-bit integer fixed-point arithmetic.
    function automatic void model(input logic [31:0] zr0, input logic [31:0] zi0,
                                  input logic [31:0] cr0, input logic [31:0] ci0,
                                  input int lim, output int n, output bit esc);
        longint zr, zi, cr, ci, sr, si, nr, ni;
        zr = longint'($signed(zr0));
        zi = longint'($signed(zi0));
        cr = longint'($signed(cr0));
        ci = longint'($signed(ci0));
        n = 0;
        esc = 1'b0;
        while (1) begin
            sr  = zr * zr;
            si  = zi * zi;
            esc = ((sr + si) >= (longint'(4) <<< (2*FRAC)));
            if (esc || n == lim) break;
            nr = ((sr - si) >>> FRAC) + cr;
            ni = ((2 * zr * zi) >>> FRAC) + ci;
            zr = longint'(int'(nr));
            zi = longint'(int'(ni));
            n++;
        end
    endfunction

    // Expected-job state, owned by the monitor.
    bit                have_exp = 1'b0;
    int                exp_cyc = 0;
    int                exp_iter = 0;
    bit                exp_esc = 1'b0;
    logic [TAG_W-1:0]  exp_tag = '0;
    int                acc_count = 0;
    int                res_count = 0;
    logic [ITER_W-1:0] last_iter = '0;
    logic              last_esc = 1'b0;
    logic [TAG_W-1:0]  last_tag = '0;
    bit                m_ev;
    int                m_n;
    bit                m_e;

    always @(negedge clk) begin
        if (!rst) begin
            have_exp = 1'b0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_iter", out_iter, 0);
            chk("rst_out_escaped", out_escaped, 0);
            chk("rst_out_tag", out_tag, 0);
        end else begin
            m_ev = have_exp && (cyc >= exp_cyc);
            chk("in_ready", in_ready, !have_exp);
            chk("out_valid", out_valid, m_ev);
            if (m_ev) begin
                chk("out_iter", out_iter, exp_iter);
                chk("out_escaped", out_escaped, exp_esc);
                chk("out_tag", out_tag, exp_tag);
            end
            if (have_exp) begin
                if (abort) begin
                    have_exp = 1'b0;
                end else if (m_ev && out_ready) begin
                    last_iter = out_iter;
                    last_esc  = out_escaped;
                    last_tag  = out_tag;
                    res_count++;
                    have_exp = 1'b0;
                end
            end else if (in_valid) begin
                model(in_re, in_im, mode ? julia_re : in_re, mode ? julia_im : in_im,
                      int'(max_iter), m_n, m_e);
                exp_iter = m_n;
                exp_esc  = m_e;
                exp_tag  = in_tag;
                exp_cyc  = cyc + 2 + m_n;
                have_exp = 1'b1;
                acc_count++;
            end
        end
    end

    bit rdy_rand = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    function automatic logic [31:0] rnd_c();
        int v;
        v = int'($urandom_range(0, 183500)) - 91750;
        return v;
    endfunction

    task automatic start_job(input logic [31:0] re, input logic [31:0] im, input logic md,
                             input logic [31:0] jr, input logic [31:0] ji,
                             input logic [ITER_W-1:0] mi, input logic [TAG_W-1:0] tg);
        int t, a0;
        a0 = acc_count;
        in_re = re; in_im = im; mode = md; julia_re = jr; julia_im = ji;
        max_iter = mi; in_tag = tg; in_valid = 1'b1;
        t = 0;
        while (acc_count == a0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        in_valid = 1'b0;
        chk("accepted", acc_count != a0, 1);
        // Scramble the request inputs; the job in flight must not see them.
        in_re = $urandom; in_im = $urandom; julia_re = $urandom; julia_im = $urandom;
        mode = 1'($urandom); max_iter = ITER_W'($urandom); in_tag = TAG_W'($urandom);
    endtask

    task automatic wait_result();
        int t, r0;
        r0 = res_count;
        t = 0;
        while (res_count == r0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("result_seen", res_count != r0, 1);
    endtask

    task automatic run_job(input logic [31:0] re, input logic [31:0] im, input logic md,
                           input logic [31:0] jr, input logic [31:0] ji,
                           input logic [ITER_W-1:0] mi, input logic [TAG_W-1:0] tg);
        start_job(re, im, md, jr, ji, mi, tg);
        wait_result();
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        while (!out_valid && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("out_valid_reached", out_valid, 1);
    endtask

    initial begin
        int pn, r0, t, a0;
        bit pe;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Model pins on hand-derived orbits.
        model(32'h0, 32'h0, 32'h0, 32'h0, 100, pn, pe);
        chk("model_c0", {pn, 31'd0, pe}, {32'd100, 32'd0});
        model(32'h00010000, 32'h0, 32'h00010000, 32'h0, 50, pn, pe);
        chk("model_c1", {pn, 31'd0, pe}, {32'd1, 32'd1});
        model(32'h0, 32'h0, 32'h00010000, 32'h0, 50, pn, pe);
        chk("model_julia", {pn, 31'd0, pe}, {32'd2, 32'd1});

        // Bounded orbit at the origin.
        run_job(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 16'd100, 20'h12345);
        chk("c0_iter", last_iter, 100);
        chk("c0_esc", last_esc, 0);
        chk("c0_tag", last_tag, 20'h12345);

        // Escaping points, including escape on the first test.
        run_job(32'h00010000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd50, 20'h00001);
        chk("c1_iter", last_iter, 1);
        chk("c1_esc", last_esc, 1);
        run_job(32'hFFFE0000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd50, 20'h00002);
        chk("cm2_iter", last_iter, 0);
        chk("cm2_esc", last_esc, 1);

        // Period-2 orbit hits the limit; a zero limit stops at once.
        run_job(32'hFFFF0000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd7, 20'h00003);
        chk("cm1_iter", last_iter, 7);
        chk("cm1_esc", last_esc, 0);
        run_job(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 20'h00004);
        chk("lim0_iter", last_iter, 0);
        chk("lim0_esc", last_esc, 0);

        // Julia mode.
        run_job(32'h0, 32'h0, 1'b1, 32'h00010000, 32'h0, 16'd50, 20'h00005);
        chk("julia_iter", last_iter, 2);
        chk("julia_esc", last_esc, 1);

        // Backpressure, then a back-to-back request.
        out_ready = 1'b0;
        start_job(32'h00010000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd50, 20'h00ABC);
        wait_out_valid();
        repeat (5) @(posedge clk);
        #1;
        in_re = 32'hFFFF0000; in_im = 32'h0; mode = 1'b0; max_iter = 16'd7;
        in_tag = 20'h00DEF; in_valid = 1'b1;
        a0 = acc_count;
        out_ready = 1'b1;
        t = 0;
        while (acc_count == a0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #1;
        in_valid = 1'b0;
        chk("b2b_accept_edges", t, 2);
        chk("bp_iter", last_iter, 1);
        chk("bp_tag", last_tag, 20'h00ABC);
        wait_result();
        chk("b2b_iter", last_iter, 7);
        chk("b2b_tag", last_tag, 20'h00DEF);

        // Abort on the tenth iteration cycle.
        start_job(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 16'd100, 20'h00006);
        r0 = res_count;
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (110) @(posedge clk);
        #1;
        chk("abort_no_result", res_count, r0);
        chk("abort_in_ready", in_ready, 1);

        // Abort while idle does not block a simultaneous request.
        abort = 1'b1;
        start_job(32'h00010000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd50, 20'h00007);
        abort = 1'b0;
        wait_result();
        chk("idle_abort_iter", last_iter, 1);
        chk("idle_abort_tag", last_tag, 20'h00007);

        // Reset in the middle of a job.
        start_job(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 16'd100, 20'h00008);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_iter", out_iter, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_job(32'hFFFE0000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd50, 20'h00009);
        chk("post_rst_tag", last_tag, 20'h00009);

        // Abort and out_ready together in DONE: abort wins.
        out_ready = 1'b0;
        start_job(32'h00010000, 32'h0, 1'b0, 32'h0, 32'h0, 16'd50, 20'h0000A);
        r0 = res_count;
        wait_out_valid();
        abort = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_abort_no_result", res_count, r0);
        chk("done_abort_in_ready", in_ready, 1);

        // Randomized jobs with random consumer stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_job(rnd_c(), rnd_c(), 1'($urandom_range(0, 1)), rnd_c(), rnd_c(),
                    ITER_W'($urandom_range(0, 30)), TAG_W'($urandom));
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
